// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 initiator and its timeout counter.
package apb4_pkg;

    localparam int PPROT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb4_mst_state_e;

    typedef struct packed {
        logic err;
        logic tmo;
    } apb4_rsp_flags_t;

endpackage

// File: rtl/apb4_master_if.sv
// Request/response handshake plus APB4 bus signals of the initiator, seen from both ends.
interface apb4_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import apb4_pkg::*;

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [ADDR_WIDTH-1:0]     req_addr_i;
    logic                      req_write_i;
    logic [DATA_WIDTH-1:0]     req_wdata_i;
    logic [DATA_WIDTH/8-1:0]   req_wstrb_i;
    logic [PPROT_W-1:0]        req_prot_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [DATA_WIDTH-1:0]     rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_tmo_o;
    logic                      busy_o;
    logic [ADDR_WIDTH-1:0]     paddr_o;
    logic [PPROT_W-1:0]        pprot_o;
    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [DATA_WIDTH-1:0]     pwdata_o;
    logic [DATA_WIDTH/8-1:0]   pstrb_o;
    logic [DATA_WIDTH-1:0]     prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, req_prot_i,
        input  rsp_ready_i, prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o, busy_o,
        output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i, req_prot_i,
        output rsp_ready_i, prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o, busy_o,
        input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

endinterface

// File: rtl/apb4_tmo_cnt.sv
// Saturating ACCESS-phase wait counter; limit_hit_o flags the last permitted wait cycle.
module apb4_tmo_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic limit_hit_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SAT      = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT_M1 = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != SAT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A zero limit disables the timeout entirely.
    assign limit_hit_o = (TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT_M1);

endmodule

// File: rtl/apb4_master.sv
// Single-outstanding APB4 initiator: valid/ready request in, SETUP/ACCESS on APB, response out.
module apb4_master
    import apb4_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk_i,
    input  logic           rst_i,
    apb4_master_if.master  bus
);

    localparam int STRB_W = DATA_WIDTH / 8;

    apb4_mst_state_e       r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic [PPROT_W-1:0]    r_pprot;
    logic [DATA_WIDTH-1:0] r_rdata;
    apb4_rsp_flags_t       r_flags;

    logic w_req_ready, w_accept, w_tmo_hit, w_in_access;
    logic w_psel, w_penable, w_rsp_valid, w_busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                w_req_ready = ~rst_i;
                if (bus.req_valid_i && !rst_i) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                w_psel      = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (bus.pready_i || w_tmo_hit) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept    = bus.req_valid_i & w_req_ready;
    assign w_in_access = (r_state == ST_ACCESS);

    // Reads drive zero data and strobes onto the bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
        end else if (w_accept) begin
            r_paddr  <= bus.req_addr_i;
            r_pwrite <= bus.req_write_i;
            r_pwdata <= bus.req_write_i ? bus.req_wdata_i : '0;
            r_pstrb  <= bus.req_write_i ? bus.req_wstrb_i : '0;
            r_pprot  <= bus.req_prot_i;
        end
    end

    // A ready slave wins over a timeout landing in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
            r_flags <= '0;
        end else if (w_in_access) begin
            if (bus.pready_i) begin
                r_rdata <= r_pwrite ? '0 : bus.prdata_i;
                r_flags <= '{err: bus.pslverr_i, tmo: 1'b0};
            end else if (w_tmo_hit) begin
                r_rdata <= '0;
                r_flags <= '{err: 1'b1, tmo: 1'b1};
            end
        end
    end

    apb4_tmo_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (r_state == ST_SETUP),
        .en_i        (w_in_access & ~bus.pready_i),
        .limit_hit_o (w_tmo_hit)
    );

    assign bus.req_ready_o = w_req_ready;
    assign bus.rsp_valid_o = w_rsp_valid;
    assign bus.rsp_rdata_o = r_rdata;
    assign bus.rsp_err_o   = r_flags.err;
    assign bus.rsp_tmo_o   = r_flags.tmo;
    assign bus.busy_o      = w_busy;
    assign bus.psel_o      = w_psel;
    assign bus.penable_o   = w_penable;
    assign bus.paddr_o     = r_paddr;
    assign bus.pwrite_o    = r_pwrite;
    assign bus.pwdata_o    = r_pwdata;
    assign bus.pstrb_o     = r_pstrb;
    assign bus.pprot_o     = r_pprot;

endmodule

// File: doc/apb4_master.md
# apb4_master

Single-outstanding APB4 initiator that converts a valid/ready request/response handshake into APB4 SETUP/ACCESS transfers. It is the requesting end for APB4 peripheral slaves such as the reset/clock control unit and other APB4 register blocks. Typical users are a bus bridge, a debug module or a boot sequencer. It handles slave wait states, forwards PSLVERR, and aborts hung transfers with a configurable timeout.

## Interface
- `ADDR_WIDTH`, default 32: width of the APB address.
- `DATA_WIDTH`, default 32: width of the APB data (multiple of 8).
- `TIMEOUT_CYCLES`, default 255: maximum number of ACCESS cycles without PREADY; 0 disables the timeout.

The block has one clock. Reset is synchronous and active-high.

- `clk_i` in 1: clock; also drives APB PCLK.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted.
- `req_addr_i` in ADDR_WIDTH: transfer address.
- `req_write_i` in 1: 1 = write, 0 = read.
- `req_wdata_i` in DATA_WIDTH: write data.
- `req_wstrb_i` in DATA_WIDTH/8: write byte strobes.
- `req_prot_i` in 3: PPROT value.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out DATA_WIDTH: read data; 0 for writes and for timeouts.
- `rsp_err_o` out 1: set on PSLVERR or timeout.
- `rsp_tmo_o` out 1: set on timeout only.
- `busy_o` out 1: high when the state is not IDLE.
- `paddr_o` out ADDR_WIDTH, `pprot_o` out 3, `psel_o` out 1, `penable_o` out 1, `pwrite_o` out 1, `pwdata_o` out DATA_WIDTH, `pstrb_o` out DATA_WIDTH/8: APB4 request signals.
- `prdata_i` in DATA_WIDTH, `pready_i` in 1, `pslverr_i` in 1: APB4 completion signals.

## Operation
- The state machine has four states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:**
  - `req_ready_o` = (state == IDLE) & ~`rst_i`.
  - On `req_valid_i` & `req_ready_o`, register address, write, wdata, strobes and prot, then go to SETUP.
  - `pstrb_o` is forced to 0 for reads.
  - `pwdata_o` is forced to 0 for reads.
- **SETUP:** `psel_o`=1, `penable_o`=0. Always goes to ACCESS after 1 cycle.
- **ACCESS:**
  - `psel_o`=1, `penable_o`=1.
  - On `pready_i`=1:
    - capture `prdata_i` for reads only (writes capture 0);
    - capture `pslverr_i` into `rsp_err_o`;
    - go to RESP.
  - On timeout, go to RESP with `rsp_err_o`=1, `rsp_tmo_o`=1, `rsp_rdata_o`=0.
- **Timeout counter:**
  - Cleared on entry to ACCESS.
  - Increments each ACCESS cycle while `pready_i`=0.
  - Timeout fires when the count equals `TIMEOUT_CYCLES`-1 and `pready_i`=0.
  - If `pready_i` is high in the same cycle the counter hits its limit, this is a normal completion, not a timeout.
  - Counter width is $clog2(`TIMEOUT_CYCLES`+1); the counter saturates and never wraps.
- **RESP:**
  - `rsp_valid_o`=1; `psel_o` and `penable_o` are 0.
  - Response fields are held stable until `rsp_ready_i`; then go to IDLE.
- APB request outputs (`paddr_o`, `pwrite_o`, `pwdata_o`, `pstrb_o`, `pprot_o`) are register outputs, held stable from SETUP through the last ACCESS cycle. They keep their value in RESP and IDLE.

## Timing
- **Reset values:**
  - all outputs 0, except `req_ready_o`, which is 1 in the first cycle after `rst_i` deasserts;
  - state is IDLE;
  - all captured registers are 0.
- **Reset mid-transfer:** at the next clock edge the FSM is in IDLE and `psel_o`/`penable_o` are 0. No response is issued, and any pending response is dropped.
- **Latency:** accept at cycle T, SETUP at T+1, ACCESS at T+2.
  - With zero wait states (`pready_i`=1 at T+2), `rsp_valid_o` is high at T+3.
  - Each wait state adds 1 cycle.
- **Throughput:** at most one transfer per 4 cycles, reached when `rsp_ready_i` is held high.
- `req_ready_o` is low from SETUP until the cycle after the response handshake completes.
- `rsp_valid_o`, once high, stays high until `rsp_ready_i`=1. There is no combinational path from `rsp_ready_i` to `req_ready_o`.
- `pready_i`, `pslverr_i` and `prdata_i` are ignored outside ACCESS.

## Structure
- Shared package `apb4_pkg`:
  - `apb4_mst_state_e` state enum (IDLE/SETUP/ACCESS/RESP, 2 bits);
  - APB PPROT width constant (3);
  - response flag struct {err, tmo}.
- Sub-module `apb4_tmo_cnt`:
  - saturating counter with clear, enable and `limit_hit_o`;
  - parameterised by `TIMEOUT_CYCLES`;
  - when `TIMEOUT_CYCLES`=0, `limit_hit_o` is tied to 0.
- Everything else stays in `apb4_master`: FSM, request register and response register.

## Test plan
- **Zero-wait write:** write addr 0x04, data 0xA5A5_0003, strb 0xF, `pready_i`=1.
  - SETUP at T+1, ACCESS at T+2, `rsp_valid_o` at T+3 with err=0, rdata=0.
  - `pwdata_o`, `paddr_o` and `pstrb_o` are stable for both APB cycles.
- **Read with 3 wait states:** `prdata_i`=0x0000_0001 driven on the `pready_i` cycle.
  - `rsp_rdata_o`=0x1 at T+6.
  - `pstrb_o`=0 throughout.
- **PSLVERR:** read with `pslverr_i`=1 together with `pready_i`.
  - `rsp_err_o`=1, `rsp_tmo_o`=0, rdata captured.
- **Timeout:** `TIMEOUT_CYCLES`=4, `pready_i` held 0.
  - `psel_o` drops after 4 ACCESS cycles.
  - Response has err=1, tmo=1, rdata=0.
  - Repeat with `pready_i` rising on the 4th ACCESS cycle: normal completion, tmo=0.
- **Response backpressure:** hold `rsp_ready_i`=0 for 5 cycles.
  - `rsp_valid_o` and its data stay stable.
  - `req_ready_o` stays 0 and a new `req_valid_i` is not accepted.
- **Reset mid-ACCESS:** assert `rst_i` during ACCESS.
  - At the next edge `psel_o`=`penable_o`=`rsp_valid_o`=0.
  - `req_ready_o`=1 the cycle after `rst_i` deasserts.
